// File: rtl/pe_pkg.sv
// Shared types, default widths and the overflow-aware adder used by the PE.
package pe_pkg;

    localparam int unsigned DefAW = 8;
    localparam int unsigned DefWW = 8;
    localparam int unsigned DefPW = 24;
    // Internal arithmetic width. A width of P_W <= 62 keeps a + b free of 64-bit overflow.
    localparam int unsigned MaxW  = 64;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWs      = 2'd1,
        StOsAcc   = 2'd2,
        StOsDrain = 2'd3
    } pe_state_e;

    // True when a + b does not fit in a signed pw-bit result.
    function automatic logic add_ovf(input logic signed [MaxW-1:0] a,
                                     input logic signed [MaxW-1:0] b,
                                     input int unsigned            pw);
        logic signed [MaxW-1:0] full;
        logic signed [MaxW-1:0] one;
        logic signed [MaxW-1:0] hi;
        one  = {{(MaxW-1){1'b0}}, 1'b1};
        full = a + b;
        hi   = (one <<< (pw - 1)) - one;
        return (full > hi) || (full < ~hi);
    endfunction

    // a + b reduced to pw bits, sign-extended back to MaxW: clamped or wrapped on overflow.
    function automatic logic signed [MaxW-1:0] add_sum(input logic signed [MaxW-1:0] a,
                                                       input logic signed [MaxW-1:0] b,
                                                       input int unsigned            pw,
                                                       input logic                   sat_en);
        logic signed [MaxW-1:0] full;
        logic signed [MaxW-1:0] one;
        logic signed [MaxW-1:0] hi;
        logic signed [MaxW-1:0] lo;
        logic signed [MaxW-1:0] wrapped;
        one     = {{(MaxW-1){1'b0}}, 1'b1};
        full    = a + b;
        hi      = (one <<< (pw - 1)) - one;
        lo      = ~hi;
        wrapped = (full <<< (MaxW - pw)) >>> (MaxW - pw);
        if (full > hi) begin
            return sat_en ? hi : wrapped;
        end else if (full < lo) begin
            return sat_en ? lo : wrapped;
        end
        return full;
    endfunction

endpackage

// File: rtl/pe_wbuf.sv
// Double-buffered weight: shadow is loaded in the background, swap copies it to active.
module pe_wbuf
    import pe_pkg::*;
#(
    parameter int unsigned W_W = DefWW
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic                  swap_i,
    input  logic signed [W_W-1:0] w_i,
    output logic signed [W_W-1:0] w_act_o
);

    logic signed [W_W-1:0] w_shd_d, w_shd_q;
    logic signed [W_W-1:0] w_act_d, w_act_q;

    // Clear beats load/swap; swap always takes the pre-edge shadow, even when loading.
    always_comb begin
        w_shd_d = w_shd_q;
        w_act_d = w_act_q;
        if (clr_i) begin
            w_shd_d = '0;
            w_act_d = '0;
        end else begin
            if (load_i) w_shd_d = w_i;
            if (swap_i) w_act_d = w_shd_q;
        end
    end

    // Weight registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_shd_q <= '0;
            w_act_q <= '0;
        end else begin
            w_shd_q <= w_shd_d;
            w_act_q <= w_act_d;
        end
    end

    assign w_act_o = w_act_q;

endmodule

// File: rtl/pe_dbw.sv
// Systolic PE: weight-stationary MAC or output-stationary accumulate with daisy-chained drain.
module pe_dbw
    import pe_pkg::*;
#(
    parameter int unsigned A_W    = DefAW,
    parameter int unsigned W_W    = DefWW,
    parameter int unsigned P_W    = DefPW,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CLR_DP,
    input  logic                  CLR_W,
    input  logic                  W_LOAD,
    input  logic signed [W_W-1:0] W_IN,
    input  logic                  W_SWAP,
    input  logic                  MODE,
    input  logic                  DRAIN,
    input  logic                  ENLeft,
    output logic                  ENRight,
    input  logic                  ENTop,
    output logic                  ENDown,
    input  logic signed [A_W-1:0] A_IN,
    output logic signed [A_W-1:0] A_OUT,
    input  logic signed [P_W-1:0] PSUM_IN,
    output logic signed [P_W-1:0] PSUM_OUT,
    output logic                  OVF
);

    logic signed [W_W-1:0] w_act;
    logic signed [MaxW-1:0] prod_x;
    logic signed [MaxW-1:0] psum_in_x;
    logic signed [MaxW-1:0] acc_x;

    pe_state_e state_d, state_q, state_eff;
    logic signed [A_W-1:0] a_out_d, a_out_q;
    logic signed [P_W-1:0] psum_d, psum_q;
    logic signed [P_W-1:0] acc_d, acc_q;
    logic en_right_d, en_right_q;
    logic en_down_d, en_down_q;
    logic ovf_d, ovf_q;
    logic en_any, en_mac;

    pe_wbuf #(
        .W_W (W_W)
    ) u_wbuf (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .clr_i   (CLR_W),
        .load_i  (W_LOAD),
        .swap_i  (W_SWAP),
        .w_i     (W_IN),
        .w_act_o (w_act)
    );

    // Product is exact at MaxW bits; the adder narrows it to P_W.
    assign prod_x    = MaxW'(A_IN) * MaxW'(w_act);
    assign psum_in_x = MaxW'(PSUM_IN);
    assign acc_x     = MaxW'(acc_q);
    assign en_any    = ENLeft | ENTop;
    assign en_mac    = ENLeft & ENTop;

    // Next-state: forwarding, mode-dependent MAC/drain, then datapath clear on top.
    always_comb begin
        a_out_d    = a_out_q;
        psum_d     = psum_q;
        acc_d      = acc_q;
        en_right_d = en_right_q;
        en_down_d  = en_down_q;
        ovf_d      = ovf_q;

        // Leaving IDLE: the triggering cycle already runs under the new state's rules.
        state_eff = state_q;
        if (state_q == StIdle && en_any) begin
            state_eff = MODE ? StOsAcc : StWs;
        end
        state_d = state_eff;

        if (en_any) begin
            a_out_d    = A_IN;
            en_right_d = ENLeft;
            en_down_d  = ENTop;
        end

        unique case (state_eff)
            StIdle: begin
            end
            StWs: begin
                if (en_mac) begin
                    psum_d = P_W'(add_sum(prod_x, psum_in_x, P_W, SAT_EN));
                    ovf_d  = ovf_q | add_ovf(prod_x, psum_in_x, P_W);
                end
            end
            StOsAcc: begin
                // Drain start wins over a same-cycle MAC, which is dropped.
                if (DRAIN) begin
                    state_d = StOsDrain;
                    psum_d  = acc_q;
                end else if (en_mac) begin
                    acc_d = P_W'(add_sum(prod_x, acc_x, P_W, SAT_EN));
                    ovf_d = ovf_q | add_ovf(prod_x, acc_x, P_W);
                end
            end
            StOsDrain: begin
                // Drain is a column shift strobe and does not depend on the data enables.
                if (DRAIN) begin
                    psum_d = PSUM_IN;
                end else begin
                    acc_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (CLR_DP) begin
            a_out_d    = '0;
            psum_d     = '0;
            acc_d      = '0;
            en_right_d = 1'b0;
            en_down_d  = 1'b0;
            ovf_d      = 1'b0;
            state_d    = StIdle;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= StIdle;
            a_out_q    <= '0;
            psum_q     <= '0;
            acc_q      <= '0;
            en_right_q <= 1'b0;
            en_down_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_out_q    <= a_out_d;
            psum_q     <= psum_d;
            acc_q      <= acc_d;
            en_right_q <= en_right_d;
            en_down_q  <= en_down_d;
            ovf_q      <= ovf_d;
        end
    end

    assign A_OUT    = a_out_q;
    assign PSUM_OUT = psum_q;
    assign ENRight  = en_right_q;
    assign ENDown   = en_down_q;
    assign OVF      = ovf_q;

endmodule
